// File: rtl/product_accumulator.sv
// Accumulates a vector of unsigned 16-bit products into a saturating ACC_W-bit sum
// and holds the result until the consumer takes it.
module product_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W:0]     sum_c;
  logic               sat_c;
  logic [ACC_W-1:0]   sat_sum_c;
  logic               accept_c;
  logic               final_c;

  // One extra bit on the adder exposes the carry used to detect saturation.
  assign accept_c  = in_valid & in_ready_q;
  assign sum_c     = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
  assign sat_c     = sum_c[ACC_W];
  assign sat_sum_c = sat_c ? '1 : sum_c[ACC_W-1:0];
  assign final_c   = (cnt_q == LAST_CNT) || in_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept_c) begin
          acc_d = sat_sum_c;
          cnt_d = cnt_q + CNT_W'(1);
          ovf_d = ovf_q | sat_c;
          if (final_c) begin
            out_sum_d   = sat_sum_c;
            out_ovf_d   = ovf_q | sat_c;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        // Handshake clears the working state; the result registers keep their last value.
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized self-checking bench: three instances (default, ACC_W=16, LEN=1) selected by sel.
module tb_product_accumulator;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_prod;

  logic [2:0]  iv, ordy, irdy, ovld, oovf;
  logic [23:0] s0, s2;
  logic [15:0] s1;

  logic        obs_rdy, obs_valid, obs_ovf;
  logic [31:0] obs_sum;

  int n_checks = 0;
  int n_pass   = 0;

  assign iv[0]   = in_valid  && (sel == 0);
  assign iv[1]   = in_valid  && (sel == 1);
  assign iv[2]   = in_valid  && (sel == 2);
  assign ordy[0] = out_ready && (sel == 0);
  assign ordy[1] = out_ready && (sel == 1);
  assign ordy[2] = out_ready && (sel == 2);

  product_accumulator u_def (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ovld[0]), .out_ready(ordy[0]), .out_sum(s0), .out_ovf(oovf[0])
  );

  product_accumulator #(.ACC_W(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ovld[1]), .out_ready(ordy[1]), .out_sum(s1), .out_ovf(oovf[1])
  );

  product_accumulator #(.LEN(1)) u_len1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(ovld[2]), .out_ready(ordy[2]), .out_sum(s2), .out_ovf(oovf[2])
  );

  always_comb begin
    obs_rdy   = irdy[0];
    obs_valid = ovld[0];
    obs_ovf   = oovf[0];
    obs_sum   = 32'(s0);
    case (sel)
      1: begin
        obs_rdy = irdy[1]; obs_valid = ovld[1]; obs_ovf = oovf[1]; obs_sum = 32'(s1);
      end
      2: begin
        obs_rdy = irdy[2]; obs_valid = ovld[2]; obs_ovf = oovf[2]; obs_sum = 32'(s2);
      end
      default: ;
    endcase
  end

  // Reference: saturating accumulation of non-negative terms equals the clamped total.
  function automatic longint max_of(input int s);
    return (s == 1) ? 64'd65535 : 64'd16777215;
  endfunction

  function automatic logic [31:0] exp_sum(input int s, input longint total);
    return (total > max_of(s)) ? 32'(max_of(s)) : 32'(total);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [15:0] p, input logic last);
    int w = 0;
    while (obs_rdy !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_checks++;
    if (obs_rdy !== 1'b1) $display("FAIL accept_wait: in_ready=%b required 1", obs_rdy);
    else n_pass++;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_prod  = 16'($urandom);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_prod = 16'hffff; in_last = 1'b1; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if ({obs_rdy, obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 1'b0, 32'd0})
        $display("FAIL reset_state[%0d]: rdy/vld/ovf/sum=%b%b%b %0d required 100 0",
                 s, obs_rdy, obs_valid, obs_ovf, obs_sum);
      else n_pass++;
    end
    sel = 0;
    tick();
    n_checks++;
    if (obs_rdy !== 1'b1) $display("FAIL reset_ready: in_ready=%b required 1", obs_rdy);
    else n_pass++;
  endtask

  task automatic test_full_vector();
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      accept(16'd65025, 1'b0);
      if (i < 7) begin
        n_checks++;
        if (obs_valid !== 1'b0) $display("FAIL full_early_valid[%0d]: out_valid=%b required 0", i, obs_valid);
        else n_pass++;
      end
    end
    n_checks++;
    if ({obs_valid, obs_rdy, obs_ovf, obs_sum} !== {1'b1, 1'b0, 1'b0, 32'd520200})
      $display("FAIL full_result: vld/rdy/ovf=%b%b%b sum=%0d required 100 520200",
               obs_valid, obs_rdy, obs_ovf, obs_sum);
    else n_pass++;
    take();
    n_checks++;
    if ({obs_valid, obs_rdy} !== 2'b01) $display("FAIL full_take: vld/rdy=%b%b required 01", obs_valid, obs_rdy);
    else n_pass++;
  endtask

  task automatic test_early_term();
    sel = 0;
    accept(16'd1, 1'b0);
    accept(16'd2, 1'b0);
    accept(16'd3, 1'b1);
    n_checks++;
    if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 32'd6})
      $display("FAIL early_result: vld/ovf=%b%b sum=%0d required 10 6", obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    take();
    for (int i = 0; i < 8; i++) accept(16'd1, 1'b0);
    n_checks++;
    if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 32'd8})
      $display("FAIL early_restart: vld/ovf=%b%b sum=%0d required 10 8", obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    take();
  endtask

  task automatic test_saturation();
    sel = 1;
    accept(16'd65025, 1'b0);
    accept(16'd65025, 1'b1);
    n_checks++;
    if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b1, 32'd65535})
      $display("FAIL sat_result: vld/ovf=%b%b sum=%0d required 11 65535", obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    take();
    accept(16'd5, 1'b1);
    n_checks++;
    if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 32'd5})
      $display("FAIL sat_clear: vld/ovf=%b%b sum=%0d required 10 5", obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    take();
  endtask

  task automatic test_backpressure();
    sel = 0;
    accept(16'd10, 1'b0);
    accept(16'd20, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_prod = 16'($urandom); in_last = 1'($urandom);
      tick();
      n_checks++;
      if ({obs_valid, obs_rdy, obs_ovf, obs_sum} !== {1'b1, 1'b0, 1'b0, 32'd30})
        $display("FAIL bp_hold[%0d]: vld/rdy/ovf=%b%b%b sum=%0d required 100 30",
                 c, obs_valid, obs_rdy, obs_ovf, obs_sum);
      else n_pass++;
    end
    in_prod = 16'd100; in_last = 1'b1;
    take();
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if ({obs_valid, obs_rdy} !== 2'b01) $display("FAIL bp_release: vld/rdy=%b%b required 01", obs_valid, obs_rdy);
    else n_pass++;
    accept(16'd7, 1'b1);
    n_checks++;
    if ({obs_valid, obs_sum} !== {1'b1, 32'd7})
      $display("FAIL bp_no_bypass: vld=%b sum=%0d required 1 7", obs_valid, obs_sum);
    else n_pass++;
    take();
  endtask

  task automatic test_reset_mid();
    sel = 0;
    for (int i = 0; i < 4; i++) accept(16'($urandom), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({obs_rdy, obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 1'b0, 32'd0})
      $display("FAIL midrst_state: rdy/vld/ovf=%b%b%b sum=%0d required 100 0",
               obs_rdy, obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    for (int i = 0; i < 8; i++) accept(16'd1, 1'b0);
    n_checks++;
    if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, 1'b0, 32'd8})
      $display("FAIL midrst_after: vld/ovf=%b%b sum=%0d required 10 8", obs_valid, obs_ovf, obs_sum);
    else n_pass++;
    take();
  endtask

  task automatic test_len1();
    logic [15:0] p;
    sel = 2;
    for (int k = 0; k < 6; k++) begin
      p = 16'($urandom);
      accept(p, 1'($urandom));
      n_checks++;
      if ({obs_valid, obs_rdy, obs_ovf, obs_sum} !== {1'b1, 1'b0, 1'b0, 32'(p)})
        $display("FAIL len1_result[%0d]: vld/rdy/ovf=%b%b%b sum=%0d required 100 %0d",
                 k, obs_valid, obs_rdy, obs_ovf, obs_sum, p);
      else n_pass++;
      for (int c = $urandom_range(0, 3); c > 0; c--) begin
        in_valid = 1'b1; in_prod = 16'($urandom);
        tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if ({obs_valid, obs_rdy, obs_sum} !== {1'b1, 1'b0, 32'(p)})
        $display("FAIL len1_hold[%0d]: vld/rdy=%b%b sum=%0d required 10 %0d", k, obs_valid, obs_rdy, obs_sum, p);
      else n_pass++;
      take();
      n_checks++;
      if ({obs_valid, obs_rdy} !== 2'b01) $display("FAIL len1_take[%0d]: vld/rdy=%b%b required 01", k, obs_valid, obs_rdy);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int          s, n;
    longint      total;
    logic [15:0] p;
    logic        last;
    for (int v = 0; v < 40; v++) begin
      s = $urandom_range(0, 1);
      sel = s;
      n = $urandom_range(1, 8);
      total = 0;
      for (int i = 0; i < n; i++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          out_ready = 1'($urandom);
          in_prod = 16'($urandom);
          tick();
        end
        out_ready = 1'($urandom);
        p = (s == 1 && $urandom_range(0, 1) == 1) ? 16'($urandom_range(40000, 65535)) : 16'($urandom);
        total += longint'(p);
        last = (i == n - 1) && (n < 8 || $urandom_range(0, 1) == 1);
        accept(p, last);
        out_ready = 1'b0;
      end
      n_checks++;
      if ({obs_valid, obs_ovf, obs_sum} !== {1'b1, (total > max_of(s)), exp_sum(s, total)})
        $display("FAIL rand_result[%0d] sel=%0d n=%0d: vld/ovf=%b%b sum=%0d required 1%b %0d",
                 v, s, n, obs_valid, obs_ovf, obs_sum, (total > max_of(s)), exp_sum(s, total));
      else n_pass++;
      for (int c = $urandom_range(0, 3); c > 0; c--) tick();
      take();
      n_checks++;
      if (obs_valid !== 1'b0) $display("FAIL rand_take[%0d]: out_valid=%b required 0", v, obs_valid);
      else n_pass++;
    end
  endtask

  initial begin
    sel = 0; rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_full_vector();
    test_early_term();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_len1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
